limbus_nios_oci_dct_packer: RTL
===============================

# limbus_nios_oci_dct_packer

Packs the Nios OCI debug trace atom stream into 30-bit compressed trace words (`dct_buffer`) with a valid-atom count (`dct_count`). The packed words feed the OCI test-bench/trace sink stage. The block also turns the simulation `test_ending` request into a drained, sticky `test_has_ended` indication. It sits between the OCI trace-atom generator and the DCT consumer.

## Interface

**Parameters**
- `ATOM_W`, 2: width of one trace atom.
- `BUF_W`, 30: packed word width; `BUF_W/ATOM_W` = 15 atoms per full word.
- `CNT_W`, 4: count width; must hold 15.
- `DCT_TIMEOUT`, 64: idle cycles before a partial flush (only with the configuration macro).

**Ports**
- `clk`, in, 1: sole clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `atom_valid`, in, 1: upstream atom present.
- `atom_data`, in, `ATOM_W`: trace atom.
- `atom_ready`, out, 1: atom accepted on the edge when `atom_valid && atom_ready`.
- `test_ending`, in, 1: request to flush and finish; level, sampled each cycle.
- `dct_valid`, out, 1: output word valid.
- `dct_ready`, in, 1: consumer accepts the word on the edge when `dct_valid && dct_ready`.
- `dct_buffer`, out, `BUF_W`: packed atoms, right-justified; newest atom in bits [1:0]; unused upper bits are 0.
- `dct_count`, out, `CNT_W`: number of valid atoms in `dct_buffer`, 1..15.
- `test_has_ended`, out, 1: sticky; set once the final word has drained.

## Operation

**Storage**
- Accumulator `acc[29:0]` with `acc_cnt` (0..15).
- One output register holding `dct_buffer`, `dct_count` and `dct_valid`.
- "Output free" means `!dct_valid || dct_ready`.

**Accept**
- On an accepted atom: `acc <= {acc[27:0], atom_data}` and `acc_cnt` increments.
- Atoms are right-justified, so the first atom of a word ends up in the highest occupied bits.

**Full word**
- An atom accepted while `acc_cnt == 14`:
  - If output is free, the word `{acc[27:0], atom_data}` loads the output register directly with count 15. `acc` clears to 0.
  - Otherwise `acc_cnt` becomes 15 and the word is held.
- While held, the word transfers to the output register on the first cycle output is free. On that transfer, `acc` and `acc_cnt` clear.

**atom_ready**
- `atom_ready = (state == RUN) && (acc_cnt != 15)`.

**State machine**
- `RUN`
  - Normal packing.
  - `test_ending == 1` → `FLUSH`. An atom presented in that same cycle is still accepted.
- `FLUSH`
  - `atom_ready = 0`.
  - If `acc_cnt > 0`, transfer the partial word when output is free: `dct_count = acc_cnt`, zero-padded above.
  - Once `acc_cnt == 0` and `dct_valid == 0` → `ENDED`.
  - Entering with an empty `acc` and an empty output reaches `ENDED` on the next edge.
- `ENDED`
  - `test_has_ended = 1`, `atom_ready = 0`.
  - Remains here until reset; `test_ending` is ignored.

**Output register rules**
- Never overwritten while `dct_valid && !dct_ready`.
- A word is never emitted with `dct_count == 0`.

**Reset**
- Reset is synchronous and has priority over all activity, including in-flight words. An in-flight word is discarded.
- Reset values: all outputs 0, `acc` 0, `acc_cnt` 0, state `RUN`.

## Timing

- Latency: `dct_valid` rises on the edge that accepts the 15th atom when output is free; the word is visible the following cycle.
- Held-full path: transfer happens on the edge where output is free. `atom_ready` returns to 1 the cycle after that transfer.
- Throughput: one atom per cycle sustained when `dct_ready` is held at 1. There is no bubble at word boundaries.
- Simultaneous handshakes: consume and load in the same edge are legal. The new word replaces the old with `dct_valid` staying 1.
- `test_has_ended` rises exactly one edge after the last word is consumed, or one edge after `FLUSH` entry if nothing was pending.

## Configuration

- `LIMBUS_DCT_TIMEOUT_EN` defined:
  - An idle counter increments each `RUN` cycle with no accepted atom while `0 < acc_cnt < 15`.
  - The counter resets on any accepted atom.
  - When it reaches `DCT_TIMEOUT`, the partial word transfers as in `FLUSH` (once output is free), and the counter clears.
- `LIMBUS_DCT_TIMEOUT_EN` undefined:
  - No counter.
  - Partial words leave only via `test_ending`.

## Test plan

- **Full word:** 15 atoms of `2'b01` back-to-back, `dct_ready = 1` → one word, `dct_buffer = 30'h15555555`, `dct_count = 15`. `dct_valid` is high for exactly 1 cycle after the 15th accept.
- **Partial flush:** atoms `11`, `10`, `01`, then `test_ending = 1` → `dct_buffer = 30'h39`, `dct_count = 3`. `test_has_ended` rises 1 cycle after consume. `atom_ready` stays 0 thereafter.
- **Backpressure:** `dct_ready = 0`, 30 atoms offered:
  - First word holds with stable data.
  - `atom_ready` drops after 30 accepts total (`acc_cnt == 15`).
  - Raising `dct_ready` yields the second word on the next cycle. No atom is lost or duplicated.
- **Reset mid-word:** 7 atoms, then `reset_n = 0` for 1 cycle → all outputs 0. The next 15 atoms produce a clean count-15 word.
- **Idle finish:** `test_ending` with an empty `acc` and no pending word → `test_has_ended = 1` after 1 edge, no `dct_valid`.
- **Timeout (with `LIMBUS_DCT_TIMEOUT_EN`):** 2 atoms `10`, `10`, then idle for 64 cycles → `dct_buffer = 30'hA`, `dct_count = 2`. Without the macro: no output.

Source files
------------

// File: rtl/limbus_nios_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into right-justified 30-bit DCT words and drains them on test_ending.
// Optional idle-timeout flush of partial words: define LIMBUS_DCT_TIMEOUT_EN.
`timescale 1ns/1ps
module limbus_nios_oci_dct_packer #(
  parameter int ATOM_W      = 2,
  parameter int BUF_W       = 30,
  parameter int CNT_W       = 4,
  parameter int DCT_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  output logic              atom_ready,
  input  logic              test_ending,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended
);

  localparam int ATOMS = BUF_W / ATOM_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ATOMS - 1);

  typedef enum logic [1:0] {RUN, FLUSH, ENDED} state_t;

  state_t            state;
  logic [BUF_W-1:0]  acc;
  logic [CNT_W-1:0]  acc_cnt;
  logic [BUF_W-1:0]  acc_shift;
  logic              out_free;
  logic              accept;
  logic              partial;
  logic              timeout_hit;
  logic              flush_acc;

  assign out_free   = !dct_valid || dct_ready;
  assign atom_ready = (state == RUN) && (acc_cnt != CNT_FULL);
  assign accept     = atom_valid && atom_ready;
  assign acc_shift  = {acc[BUF_W-ATOM_W-1:0], atom_data};
  assign partial    = (acc_cnt != '0) && (acc_cnt != CNT_FULL);

`ifdef LIMBUS_DCT_TIMEOUT_EN
  localparam int IDLE_W = $clog2(DCT_TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == IDLE_W'(DCT_TIMEOUT));

  // Counts idle RUN cycles while a partial word sits in the accumulator
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (accept || (state != RUN) || !partial) begin
      idle_cnt <= '0;
    end else if (timeout_hit) begin
      if (out_free) idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  // Timeout disabled: partial words leave only through test_ending.
  assign timeout_hit = (DCT_TIMEOUT < 0);
`endif

  // Whole accumulator moves to the output register this edge
  always_comb begin
    flush_acc = 1'b0;
    if (out_free) begin
      if (state == RUN)
        flush_acc = (acc_cnt == CNT_FULL) || (!accept && timeout_hit && partial);
      else if (state == FLUSH)
        flush_acc = (acc_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= RUN;
      acc            <= '0;
      acc_cnt        <= '0;
      dct_valid      <= 1'b0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      test_has_ended <= 1'b0;
    end else begin
      if (dct_valid && dct_ready)
        dct_valid <= 1'b0;

      if (flush_acc) begin
        dct_buffer <= acc;
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
        acc        <= '0;
        acc_cnt    <= '0;
      end else if (accept) begin
        // Completing word bypasses the accumulator when the output can take it
        if ((acc_cnt == CNT_LAST) && out_free) begin
          dct_buffer <= acc_shift;
          dct_count  <= CNT_FULL;
          dct_valid  <= 1'b1;
          acc        <= '0;
          acc_cnt    <= '0;
        end else begin
          acc     <= acc_shift;
          acc_cnt <= acc_cnt + CNT_W'(1);
        end
      end

      case (state)
        RUN: begin
          if (test_ending) state <= FLUSH;
        end
        FLUSH: begin
          if ((acc_cnt == '0) && !dct_valid) begin
            state          <= ENDED;
            test_has_ended <= 1'b1;
          end
        end
        default: begin
          test_has_ended <= 1'b1;
        end
      endcase
    end
  end

endmodule
